// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   state_t          FSM state encoding (IDLE, READ, WRITE, RESP)
//   F3_*             RV32I load/store funct3 codes
//   f3_legal()       funct3 legality for a load or a store
//   misaligned()     natural-alignment check for the access size
//   align_offset()   byte offset with the sub-size address bits cleared
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!write) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  // Size is carried in funct3[1:0]: 00 byte, 01 halfword, 10 word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] off;
    case (f3[1:0])
      2'b00:   off = lo;
      2'b01:   off = {lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the load/store unit.
//   funct3      access size (bits 1:0) and unsigned flag (bit 2)
//   offset      byte offset within the word, already aligned to the size
//   mem_word    word read from ram
//   store_data  right-aligned store data
//   load_data   selected lane, sign- or zero-extended
//   merged      mem_word with the store lane replaced (word stores pass store_data)
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = mem_word >> {offset, 3'b000};
    load_data = shifted;
    merged    = store_data;
    case (funct3[1:0])
      2'b00: begin
        load_data = funct3[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        merged    = mem_word;
        merged[{offset, 3'b000} +: 8] = store_data[7:0];
      end
      2'b01: begin
        load_data = funct3[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        merged    = mem_word;
        merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit in front of a word-addressed ram with
// combinational read and clocked full-word write.
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_write, req_funct3,
//   req_addr, req_wdata             request payload (byte address, right-aligned data)
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_err            extended load data (0 for stores), error flag
//   mem_read, mem_write, mem_addr,
//   mem_wdata, mem_rdata            ram port (mem_addr is a word index)
// Build option: LSU_ALIGN_CHECK_EN flags misaligned / illegal-funct3 requests
// on resp_err with no memory access; otherwise resp_err stays 0, illegal
// funct3 acts as a word access and offending low address bits are ignored.
//
// state | meaning
// IDLE  | ready for a request
// READ  | ram word read; load result or sub-word merge formed
// WRITE | one-cycle ram write of mem_wdata
// RESP  | response held until resp_ready
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        write_q;

  logic [2:0]  f3_eff;
  logic [1:0]  off_eff;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  always_comb begin
    f3_eff  = req_funct3;
    off_eff = req_addr[1:0];
    req_err = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    req_err = !f3_legal(req_write, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
    if (!f3_legal(req_write, req_funct3)) f3_eff = F3_W;
    off_eff = align_offset(f3_eff, req_addr[1:0]);
`endif
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .offset     (off_q),
    .mem_word   (mem_rdata),
    .store_data (wdata_q),
    .load_data  (load_data),
    .merged     (merged_word)
  );

  assign req_ready = (state == IDLE);
  // Gated by rst_n so a reset landing in WRITE never commits to ram.
  assign mem_read  = (state == READ)  && rst_n;
  assign mem_write = (state == WRITE) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q       <= f3_eff;
            off_q      <= off_eff;
            wdata_q    <= req_wdata;
            write_q    <= req_write;
            mem_addr   <= {2'b00, req_addr[31:2]};
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (req_err) begin
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_write && (f3_eff == F3_W)) begin
              mem_wdata <= req_wdata;
              state     <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (write_q) begin
            mem_wdata <= merged_word;
            state     <= WRITE;
          end else begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          mem_wdata  <= '0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // ram: 16 words, low index bits of mem_addr decoded
  logic [31:0] ram [16];
  logic [31:0] model_ram [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_val = 32'd0;

  assign mem_rdata = ram[mem_addr[3:0]];

  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_val;
    else if (mem_write) ram[mem_addr[3:0]] <= mem_wdata;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs after an accept
  typedef struct {
    bit          rd;
    bit          wr;
    bit          rv;
    bit          rdy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  bit   chk_en = 1'b0;

  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  logic [31:0] last_wdata = 32'd0;
  logic [31:0] last_rd_addr = 32'd0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;

  always @(negedge clk) begin : compare
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{rd: 1'b0, wr: 1'b0, rv: 1'b0, rdy: 1'b1, addr: 32'd0,
                 wdata: 32'd0, rdata: 32'd0, err: 1'b0};
      chk("req_ready", 32'(req_ready), 32'(e.rdy));
      chk("mem_read", 32'(mem_read), 32'(e.rd));
      chk("mem_write", 32'(mem_write), 32'(e.wr));
      chk("resp_valid", 32'(resp_valid), 32'(e.rv));
      chk("mem_wdata", mem_wdata, e.wr ? e.wdata : 32'd0);
      if (e.rd || e.wr) chk("mem_addr", mem_addr, e.addr);
      if (e.rv) begin
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
      if (mem_read) begin rd_pulses++; last_rd_addr = mem_addr; end
      if (mem_write) begin wr_pulses++; last_wdata = mem_wdata; end
      if (resp_valid) begin last_rdata = resp_rdata; last_err = resp_err; end
    end
  end

  // Reference behaviour from the ISA rules, byte by byte.
  function automatic void model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] word, input logic [31:0] d,
                                output bit err, output logic [31:0] rdata,
                                output logic [31:0] nword, output int sz);
    bit legal;
    int off;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) sz = 4;
    else if (f3[1:0] == 2'd0) sz = 1;
    else if (f3[1:0] == 2'd1) sz = 2;
    else sz = 4;
    off = int'(a % 4);
`ifdef LSU_ALIGN_CHECK_EN
    err = !legal || (off % sz != 0);
`else
    err = 1'b0;
    off = off - (off % sz);
`endif
    rdata = 32'd0;
    nword = word;
    if (!err) begin
      if (!w) begin
        for (int i = 0; i < sz; i++) rdata[8*i +: 8] = word[8*(off+i) +: 8];
        if (legal && !f3[2] && sz < 4 && rdata[8*sz-1])
          for (int i = sz; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
      end else begin
        for (int i = 0; i < sz; i++) nword[8*(off+i) +: 8] = d[8*i +: 8];
      end
    end
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1;
    pre_idx = 4'(idx);
    pre_val = val;
    model_ram[idx] = val;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int stall);
    bit          err;
    logic [31:0] rdata, nword, widx;
    int          sz, npre;
    exp_t        r;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
    resp_ready = (stall == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    model(w, f3, a, model_ram[a[5:2]], d, err, rdata, nword, sz);
    widx = {2'b00, a[31:2]};
    npre = 0;
    if (!err) begin
      if (!w || sz < 4) begin
        r = '{rd: 1'b1, wr: 1'b0, rv: 1'b0, rdy: 1'b0, addr: widx,
              wdata: 32'd0, rdata: 32'd0, err: 1'b0};
        exp_q.push_back(r);
        npre++;
      end
      if (w) begin
        r = '{rd: 1'b0, wr: 1'b1, rv: 1'b0, rdy: 1'b0, addr: widx,
              wdata: nword, rdata: 32'd0, err: 1'b0};
        exp_q.push_back(r);
        npre++;
        model_ram[a[5:2]] = nword;
      end
    end
    for (int i = 0; i <= stall; i++) begin
      r = '{rd: 1'b0, wr: 1'b0, rv: 1'b1, rdy: 1'b0, addr: 32'd0,
            wdata: 32'd0, rdata: rdata, err: err};
      exp_q.push_back(r);
    end
    repeat (npre + stall + 1) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          m_err;
    logic [31:0] m_rd, m_nw;
    int          m_sz, p0, w0;

    // pin the model with hand-computed values
    model(1'b0, F3_B, 32'h13, 32'h80FF0000, 32'd0, m_err, m_rd, m_nw, m_sz);
    chk("model_lb", m_rd, 32'hFFFFFF80);
    model(1'b0, F3_HU, 32'h12, 32'h80FF0000, 32'd0, m_err, m_rd, m_nw, m_sz);
    chk("model_lhu", m_rd, 32'h000080FF);
    model(1'b1, F3_B, 32'h11, 32'h11223344, 32'h000000AB, m_err, m_rd, m_nw, m_sz);
    chk("model_sb", m_nw, 32'h1122AB44);

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) preload(i, $urandom);
    chk_en = 1'b1;

    // directed cases
    preload(4, 32'hDEADBEEF);
    do_req(1'b0, F3_W, 32'h10, 32'd0, 0);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    chk("lw_addr", last_rd_addr, 32'd4);
    chk("lw_err", 32'(last_err), 32'd0);

    preload(4, 32'h80FF0000);
    do_req(1'b0, F3_B, 32'h13, 32'd0, 0);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, F3_BU, 32'h13, 32'd0, 1);
    chk("lbu_rdata", last_rdata, 32'h00000080);
    do_req(1'b0, F3_HU, 32'h12, 32'd0, 0);
    chk("lhu_rdata", last_rdata, 32'h000080FF);

    preload(4, 32'h11223344);
    w0 = wr_pulses;
    do_req(1'b1, F3_B, 32'h11, 32'h000000AB, 0);
    chk("sb_wdata", last_wdata, 32'h1122AB44);
    chk("sb_writes", 32'(wr_pulses - w0), 32'd1);
    chk("sb_ram", ram[4], 32'h1122AB44);

`ifdef LSU_ALIGN_CHECK_EN
    preload(0, 32'hCAFEF00D);
    p0 = rd_pulses;
    w0 = wr_pulses;
    do_req(1'b1, F3_H, 32'h03, 32'h00001234, 0);
    chk("sh_mis_err", 32'(last_err), 32'd1);
    chk("sh_mis_reads", 32'(rd_pulses - p0), 32'd0);
    chk("sh_mis_writes", 32'(wr_pulses - w0), 32'd0);
    chk("sh_mis_ram", ram[0], 32'hCAFEF00D);
`endif

    w0 = wr_pulses;
    do_req(1'b1, F3_W, 32'h20, 32'h5A5AA5A5, 3);
    chk("sw_stall_writes", 32'(wr_pulses - w0), 32'd1);
    chk("sw_stall_ram", ram[8], 32'h5A5AA5A5);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      do_req(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), a, $urandom,
             int'($urandom_range(2, 0)));
    end

    for (int i = 0; i < 16; i++) chk("ram_final", ram[i], model_ram[i]);

    // reset during the WRITE of a byte store
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    preload(4, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_funct3 = F3_B;
    req_addr = 32'h11;
    req_wdata = 32'h000000AB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstw_read_phase", 32'(mem_read), 32'd1);
    @(negedge clk);
    chk("rstw_write_phase", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_write_gated", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_ram", ram[4], 32'h11223344);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_resp_err", 32'(resp_err), 32'd0);
    chk("rstw_resp_rdata", resp_rdata, 32'd0);
    chk("rstw_mem_addr", mem_addr, 32'd0);
    chk("rstw_mem_wdata", mem_wdata, 32'd0);
    chk("rstw_mem_read", 32'(mem_read), 32'd0);
    chk("rstw_mem_write", 32'(mem_write), 32'd0);
    chk("rstw_req_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's ALU result (effective address) and the word-addressed data `ram`. It accepts one RV32I load or store request, performs byte/halfword/word alignment, sign/zero extension and read-modify-write for sub-word stores, and returns the result over a valid/ready handshake. The `ram` has a combinational read and a clocked full-word write.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU idle and able to accept.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (size/sign).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  load result, extended; 0 for stores.
- `resp_err`  out  1  misaligned or illegal funct3; access suppressed.
- `mem_read`  out  1  to `ram` read.
- `mem_write`  out  1  to `ram` write.
- `mem_addr`  out  32  word index = captured `req_addr[31:2]`, zero-extended.
- `mem_wdata`  out  32  full word to write.
- `mem_rdata`  in  32  word from `ram`, valid the same cycle as `mem_read`.

## Operation
- Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, capture the request. On error, go to RESP with `resp_err`=1 and no memory access. For a load or SB/SH, go to READ. For SW, go to WRITE with `mem_wdata`=`req_wdata`.
- READ: `mem_read`=1 and capture `mem_rdata`.
  - Load: select the lane by `addr[1:0]`, extend it (sign for LB/LH, zero for LBU/LHU), then go to RESP.
  - SB/SH: merge the store lane into the captured word, leave the other bytes unchanged, then go to WRITE.
- WRITE: `mem_write`=1 for exactly one cycle, then go to RESP.
- RESP: `resp_valid`=1. Hold `resp_rdata` and `resp_err` stable until `resp_ready`, then go to IDLE. A new request is accepted no earlier than the cycle after.
- `mem_read`, `mem_write` and `mem_wdata` are driven only in their own state; otherwise they are 0.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State goes to IDLE.
  - `resp_valid`, `resp_err`, `resp_rdata`, `mem_addr` and `mem_wdata` go to 0.
- `mem_read` and `mem_write` are combinationally gated by `rst_n`. While `rst_n`=0 they are 0, so reset during WRITE never commits a write.
- Latency from the accept edge to the first `resp_valid` cycle, with `resp_ready`=1:
  - LW/LH/LB: 2 cycles (READ, RESP).
  - SW: 2 cycles (WRITE, RESP).
  - SB/SH: 3 cycles (READ, WRITE, RESP).
  - Error: 1 cycle (RESP).
- Throughput: at most one request in flight. `req_ready`=0 outside IDLE.
- If `resp_ready`=0, the LSU stays in RESP indefinitely with outputs frozen.
- Address wrap: `req_addr[31:2]` is passed through unchanged. The `ram` decodes its low index bits.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Misaligned and illegal-funct3 requests are flagged on `resp_err` and never reach memory.
- Not defined:
  - `resp_err` is tied to 0.
  - Illegal funct3 is treated as word size.
  - Misaligned halfword/word accesses ignore the offending low address bits: they are forced to 0 for lane selection and merge.

## Structure
- `lsu_pkg` holds:
  - the state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2, RESP=2'd3);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the misalignment check function.
- Sub-module `lsu_align` (combinational) contains:
  - load lane extract and extend;
  - store lane merge, from `funct3`, `addr[1:0]`, the memory word and the store data.

## Test plan
- LW at 0x10, ram[4]=0xDEADBEEF → `mem_read` in cycle 1, `mem_addr`=4; `resp_rdata`=0xDEADBEEF and `resp_err`=0 in cycle 2.
- LB at 0x13 with ram[4]=0x80FF0000 → `resp_rdata`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x12 → 0x000080FF.
- SB of 0x000000AB at 0x11 with ram[4]=0x11223344 → sequence READ, WRITE, RESP. One write with `mem_wdata`=0x1122AB44.
- SH at 0x03, with the macro defined → `resp_err`=1 one cycle after accept, no `mem_read`/`mem_write`, ram unchanged.
- SW at 0x20 with `resp_ready` held 0 for 3 cycles → a single `mem_write` pulse; `resp_valid` held 3 cycles, then IDLE after `resp_ready`.
- Assert `rst_n`=0 during WRITE of SB → `mem_write`=0 that cycle, ram unchanged, all outputs 0 on the next cycle, `req_ready`=1.
